// File: rtl/tpulse_monitor.sv
// tpulse_monitor
//    Receiving end of a counter terminal-pulse stream. Measures the number of
//    clk cycles between successive rising edges of tpulse_in, compares each
//    measured period with a loadable expected value, and tracks mismatches,
//    pulse count and loss of the pulse stream.
//
//    Optional feature macro: TPULSE_MON_HIST_EN
//       defined   : period_min / period_max track the extremes of reported periods
//       undefined : period_min tied to all ones, period_max tied to zero
//
// Ports
//    clk           in   system clock, rising edge
//    reset         in   synchronous active-high reset
//    tpulse_in     in   terminal pulse (may be held high for several cycles)
//    expect_load   in   load strobe for expected period
//    expect_value  in   expected period, WIDTH bits (zero-extended to CW)
//    period_out    out  last measured period
//    period_valid  out  one-cycle strobe when period_out updates
//    match         out  last measured period equalled expected
//    mismatch_cnt  out  saturating mismatch count
//    pulse_cnt     out  wrapping count of detected pulse edges
//    timeout       out  pulse stream lost (level)
//    period_min    out  smallest reported period
//    period_max    out  largest reported period
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for the first edge; no period reference yet
// MEASURE | counting cycles since the last edge
// LOST    | no edge for TIMEOUT cycles; counter parked at TIMEOUT

module tpulse_monitor #(
   parameter int WIDTH   = 8,
   parameter int CW      = 9,
   parameter int TIMEOUT = 511
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tpulse_in,
   input  logic             expect_load,
   input  logic [WIDTH-1:0] expect_value,
   output logic [CW-1:0]    period_out,
   output logic             period_valid,
   output logic             match,
   output logic [7:0]       mismatch_cnt,
   output logic [15:0]      pulse_cnt,
   output logic             timeout,
   output logic [CW-1:0]    period_min,
   output logic [CW-1:0]    period_max
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MEASURE = 2'd1;
   localparam logic [1:0] S_LOST    = 2'd2;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic          prev_q, prev_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] expected_q, expected_d;
   logic [CW-1:0] period_q, period_d;
   logic          valid_q, valid_d;
   logic          match_q, match_d;
   logic [7:0]    mism_q, mism_d;
   logic [15:0]   pcnt_q, pcnt_d;
   logic          timeout_q, timeout_d;
   logic          edge_det;

`ifdef TPULSE_MON_HIST_EN
   logic [CW-1:0] pmin_q, pmin_d;
   logic [CW-1:0] pmax_q, pmax_d;
`endif

   // prev resets high so a level held through reset is not seen as an edge
   assign edge_det = tpulse_in & ~prev_q;

   always_comb begin
      state_d    = state_q;
      prev_d     = tpulse_in;
      cnt_d      = cnt_q;
      expected_d = expected_q;
      period_d   = period_q;
      valid_d    = 1'b0;
      match_d    = match_q;
      mism_d     = mism_q;
      pcnt_d     = pcnt_q;
      timeout_d  = timeout_q;
`ifdef TPULSE_MON_HIST_EN
      pmin_d     = pmin_q;
      pmax_d     = pmax_q;
`endif

      if (edge_det) begin
         pcnt_d = pcnt_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (edge_det) begin
               state_d = S_MEASURE;
               cnt_d   = CNT_ONE;
            end
         end
         S_MEASURE: begin
            if (edge_det) begin
               period_d = cnt_q;
               valid_d  = 1'b1;
               match_d  = (cnt_q == expected_q);
               cnt_d    = CNT_ONE;
               if ((cnt_q != expected_q) && (mism_q != 8'hFF)) begin
                  mism_d = mism_q + 8'd1;
               end
`ifdef TPULSE_MON_HIST_EN
               if (cnt_q < pmin_q) pmin_d = cnt_q;
               if (cnt_q > pmax_q) pmax_d = cnt_q;
`endif
            end else begin
               // lands on TIMEOUT when the stream is declared lost, then holds
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  state_d   = S_LOST;
                  timeout_d = 1'b1;
               end
            end
         end
         S_LOST: begin
            // recovery edge only restarts the measurement; no period reported
            if (edge_det) begin
               state_d   = S_MEASURE;
               cnt_d     = CNT_ONE;
               timeout_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // the compare above used the old expected value; the clears win
      if (expect_load) begin
         expected_d = CW'(expect_value);
         match_d    = 1'b0;
         mism_d     = 8'd0;
`ifdef TPULSE_MON_HIST_EN
         pmin_d     = '1;
         pmax_d     = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         prev_q     <= 1'b1;
         cnt_q      <= '0;
         expected_q <= '0;
         period_q   <= '0;
         valid_q    <= 1'b0;
         match_q    <= 1'b0;
         mism_q     <= 8'd0;
         pcnt_q     <= 16'd0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         cnt_q      <= cnt_d;
         expected_q <= expected_d;
         period_q   <= period_d;
         valid_q    <= valid_d;
         match_q    <= match_d;
         mism_q     <= mism_d;
         pcnt_q     <= pcnt_d;
         timeout_q  <= timeout_d;
      end
   end

`ifdef TPULSE_MON_HIST_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         pmin_q <= '1;
         pmax_q <= '0;
      end else begin
         pmin_q <= pmin_d;
         pmax_q <= pmax_d;
      end
   end

   assign period_min = pmin_q;
   assign period_max = pmax_q;
`else
   assign period_min = '1;
   assign period_max = '0;
`endif

   assign period_out   = period_q;
   assign period_valid = valid_q;
   assign match        = match_q;
   assign mismatch_cnt = mism_q;
   assign pulse_cnt    = pcnt_q;
   assign timeout      = timeout_q;

endmodule
